ram_wr_drain_queue: RTL and testbench

//  Write-side feeder for the 1-read/2-write register RAM. Collects up to NUM_IN write requests per cycle from

---
 rtl/ram_wr_drain_queue_pkg.sv | 39 +++
 rtl/ram_wr_drain_queue_fwd_cam.sv | 35 +++
 rtl/ram_wr_drain_queue.sv | 123 ++++++++++++
 tb/tb_ram_wr_drain_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ram_wr_drain_queue_pkg.sv
// Shared types, sizes and helper functions for the RAM write-drain queue.
package ram_wr_drain_queue_pkg;

  localparam int WIDTH  = 8;
  localparam int INDEX  = 4;
  localparam int NUM_IN = 3;
  localparam int QDEPTH = 8;
  localparam int QIDX   = 3;

  typedef struct packed {
    logic [INDEX-1:0] addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  // Number of valid lanes in a request pattern.
  function automatic logic [QIDX:0] popcount(input logic [NUM_IN-1:0] vld);
    logic [QIDX:0] cnt;
    cnt = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      cnt = cnt + (QIDX+1)'(vld[j]);
    end
    return cnt;
  endfunction

  // Compacted slot offset of a lane: number of valid lanes older than it.
  function automatic logic [QIDX-1:0] lane_offset(input logic [NUM_IN-1:0] vld, input int lane);
    logic [QIDX-1:0] cnt;
    cnt = '0;
    for (int j = 0; j < NUM_IN; j++) begin
      if ((j < lane) && vld[j]) begin
        cnt = cnt + QIDX'(1);
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ram_wr_drain_queue_fwd_cam.sv
// Age-ordered address match over the live queue window; the youngest hit wins.
module wr_queue_fwd_cam
  import ram_wr_drain_queue_pkg::*;
(
  input  logic [QDEPTH*INDEX-1:0] ent_addr_i,
  input  logic [QDEPTH*WIDTH-1:0] ent_data_i,
  input  logic [QIDX-1:0]         head_i,
  input  logic [QIDX:0]           count_i,
  input  logic [INDEX-1:0]        fwd_addr_i,
  output logic                    fwd_hit_o,
  output logic [WIDTH-1:0]        fwd_data_o
);

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    logic [QIDX-1:0] idx;
    logic [QIDX:0]   age;
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    idx        = head_i;
    age        = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      idx = head_i + k[QIDX-1:0];
      age = k[QIDX:0];
      if ((age < count_i) && (ent_addr_i[int'(idx)*INDEX +: INDEX] == fwd_addr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = ent_data_i[int'(idx)*WIDTH +: WIDTH];
      end else begin
        fwd_hit_o  = fwd_hit_o;
        fwd_data_o = fwd_data_o;
      end
    end
  end

endmodule

// File: rtl/ram_wr_drain_queue.sv
// In-order circular write queue feeding the two RAM write ports, with forwarding.
module ram_wr_drain_queue
  import ram_wr_drain_queue_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         req_vld_i,
  input  logic [NUM_IN*INDEX-1:0]   req_addr_i,
  input  logic [NUM_IN*WIDTH-1:0]   req_data_i,
  output logic                      ready_o,
  input  logic                      stall_i,
  output logic [INDEX-1:0]          addr0wr_o,
  output logic [WIDTH-1:0]          data0wr_o,
  output logic                      we0_o,
  output logic [INDEX-1:0]          addr1wr_o,
  output logic [WIDTH-1:0]          data1wr_o,
  output logic                      we1_o,
  input  logic [INDEX-1:0]          fwd_addr_i,
  output logic                      fwd_hit_o,
  output logic [WIDTH-1:0]          fwd_data_o,
  output logic [QIDX:0]             count_o
);

  wr_req_t               mem_q [QDEPTH];
  wr_req_t               mem_d [QDEPTH];
  wr_req_t               lane_req_s [NUM_IN];
  logic [QIDX-1:0]       head_q, head_d, tail_q, tail_d;
  logic [QIDX:0]         count_q, count_d;
  logic                  ready_q, ready_d;
  logic [1:0]            drain_n_s;
  logic [QIDX:0]         enq_n_s;
  logic [QIDX-1:0]       head_p1_s;
  logic [QDEPTH*INDEX-1:0] ent_addr_s;
  logic [QDEPTH*WIDTH-1:0] ent_data_s;

  // Split the flat lane buses into request structs.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      lane_req_s[i].addr = req_addr_i[i*INDEX +: INDEX];
      lane_req_s[i].data = req_data_i[i*WIDTH +: WIDTH];
    end
  end

  // Drain up to two oldest entries unless stalled; ports are gated to zero when idle.
  always_comb begin
    head_p1_s = head_q + QIDX'(1);
    if (stall_i) begin
      drain_n_s = 2'd0;
    end else if (count_q >= (QIDX+1)'(2)) begin
      drain_n_s = 2'd2;
    end else begin
      drain_n_s = count_q[1:0];
    end
    we0_o     = (drain_n_s != 2'd0);
    we1_o     = (drain_n_s == 2'd2);
    addr0wr_o = we0_o ? mem_q[head_q].addr    : '0;
    data0wr_o = we0_o ? mem_q[head_q].data    : '0;
    addr1wr_o = we1_o ? mem_q[head_p1_s].addr : '0;
    data1wr_o = we1_o ? mem_q[head_p1_s].data : '0;
  end

  // Compact valid lanes into consecutive slots at the tail and update pointers.
  always_comb begin
    mem_d   = mem_q;
    enq_n_s = '0;
    if (ready_q) begin
      enq_n_s = popcount(req_vld_i);
      for (int i = 0; i < NUM_IN; i++) begin
        mem_d[tail_q + lane_offset(req_vld_i, i)] =
          req_vld_i[i] ? lane_req_s[i] : mem_d[tail_q + lane_offset(req_vld_i, i)];
      end
    end else begin
      enq_n_s = '0;
    end
    tail_d  = tail_q + enq_n_s[QIDX-1:0];
    head_d  = head_q + QIDX'(drain_n_s);
    count_d = count_q + enq_n_s - (QIDX+1)'(drain_n_s);
    ready_d = (((QIDX+1)'(QDEPTH) - count_d) >= (QIDX+1)'(NUM_IN));
  end

  // Queue state registers; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      for (int e = 0; e < QDEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
      for (int e = 0; e < QDEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
    end
  end

  // Flatten storage for the forwarding search.
  always_comb begin
    for (int e = 0; e < QDEPTH; e++) begin
      ent_addr_s[e*INDEX +: INDEX] = mem_q[e].addr;
      ent_data_s[e*WIDTH +: WIDTH] = mem_q[e].data;
    end
  end

  wr_queue_fwd_cam u_fwd_cam (
    .ent_addr_i (ent_addr_s),
    .ent_data_i (ent_data_s),
    .head_i     (head_q),
    .count_i    (count_q),
    .fwd_addr_i (fwd_addr_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_data_o (fwd_data_o)
  );

  assign ready_o = ready_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_ram_wr_drain_queue.sv
// Randomized plus directed bench against a queue-based reference model.
module tb_ram_wr_drain_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_vld_i;
  logic [11:0] req_addr_i;
  logic [23:0] req_data_i;
  logic        ready_o;
  logic        stall_i;
  logic [3:0]  addr0wr_o, addr1wr_o;
  logic [7:0]  data0wr_o, data1wr_o;
  logic        we0_o, we1_o;
  logic [3:0]  fwd_addr_i;
  logic        fwd_hit_o;
  logic [7:0]  fwd_data_o;
  logic [3:0]  count_o;

  ram_wr_drain_queue dut (
    .clk(clk), .reset(reset),
    .req_vld_i(req_vld_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .ready_o(ready_o), .stall_i(stall_i),
    .addr0wr_o(addr0wr_o), .data0wr_o(data0wr_o), .we0_o(we0_o),
    .addr1wr_o(addr1wr_o), .data1wr_o(data1wr_o), .we1_o(we1_o),
    .fwd_addr_i(fwd_addr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t q[$];
  logic m_ready;
  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive inputs at negedge and compare all outputs against the model.
  task automatic step_drive(input logic r, input logic [2:0] v, input logic [11:0] a,
                            input logic [23:0] d, input logic st, input logic [3:0] fa);
    int   n;
    logic hit;
    logic [7:0] fd;
    @(negedge clk);
    reset = r; req_vld_i = v; req_addr_i = a; req_data_i = d; stall_i = st; fwd_addr_i = fa;
    #1;
    n = st ? 0 : ((q.size() >= 2) ? 2 : q.size());
    check_val("we0", 32'(we0_o), 32'(n >= 1));
    check_val("we1", 32'(we1_o), 32'(n == 2));
    if (n >= 1) begin
      check_val("addr0", 32'(addr0wr_o), 32'(q[0].a));
      check_val("data0", 32'(data0wr_o), 32'(q[0].d));
    end
    if (n == 2) begin
      check_val("addr1", 32'(addr1wr_o), 32'(q[1].a));
      check_val("data1", 32'(data1wr_o), 32'(q[1].d));
    end
    check_val("count", 32'(count_o), 32'(q.size()));
    check_val("ready", 32'(ready_o), 32'(m_ready));
    hit = 1'b0; fd = 8'h00;
    foreach (q[i]) if (q[i].a == fa) begin hit = 1'b1; fd = q[i].d; end
    check_val("fwd_hit", 32'(fwd_hit_o), 32'(hit));
    check_val("fwd_data", 32'(fwd_data_o), 32'(fd));
  endtask

  // Advance the model across the clock edge using the held inputs.
  task automatic step_commit();
    int n;
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      n = stall_i ? 0 : ((q.size() >= 2) ? 2 : q.size());
      repeat (n) void'(q.pop_front());
      if (m_ready) begin
        for (int i = 0; i < 3; i++) begin
          if (req_vld_i[i]) q.push_back('{a: req_addr_i[i*4 +: 4], d: req_data_i[i*8 +: 8]});
        end
      end
      m_ready = ((8 - q.size()) >= 3);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] v, input logic [11:0] a,
                      input logic [23:0] d, input logic st, input logic [3:0] fa);
    step_drive(r, v, a, d, st, fa);
    step_commit();
  endtask

  initial begin
    logic [11:0] ra;
    logic [23:0] rd;
    reset = 1'b1; req_vld_i = 3'b000; req_addr_i = 12'h000; req_data_i = 24'h000000;
    stall_i = 1'b0; fwd_addr_i = 4'h0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    q.delete();

    // 1: idle after reset
    repeat (5) step(1'b0, 3'b000, 12'h000, 24'h0, 1'b0, 4'h3);

    // 2: three lanes in one cycle
    step(1'b0, 3'b111, {4'd7, 4'd5, 4'd3}, {8'h33, 8'h22, 8'h11}, 1'b0, 4'h0);
    step_drive(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h7);
    check_val("t2_a0", 32'(addr0wr_o), 32'd3);
    check_val("t2_d0", 32'(data0wr_o), 32'h11);
    check_val("t2_a1", 32'(addr1wr_o), 32'd5);
    check_val("t2_d1", 32'(data1wr_o), 32'h22);
    step_commit();
    step_drive(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h7);
    check_val("t2_a0b", 32'(addr0wr_o), 32'd7);
    check_val("t2_d0b", 32'(data0wr_o), 32'h33);
    check_val("t2_we1", 32'(we1_o), 32'd0);
    step_commit();
    step(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h0);

    // 3: same address on lanes 0 and 2
    step(1'b0, 3'b101, {4'd4, 4'd9, 4'd4}, {8'hBB, 8'h55, 8'hAA}, 1'b0, 4'h4);
    step_drive(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h4);
    check_val("t3_d0", 32'(data0wr_o), 32'hAA);
    check_val("t3_d1", 32'(data1wr_o), 32'hBB);
    check_val("t3_hit", 32'(fwd_hit_o), 32'd1);
    check_val("t3_fwd", 32'(fwd_data_o), 32'hBB);
    step_commit();

    // 4: stall fills to 6, further requests ignored, then drain
    repeat (2) step(1'b0, 3'b111, 12'h123, 24'h445566, 1'b1, 4'h2);
    step_drive(1'b0, 3'b111, 12'h789, 24'h778899, 1'b1, 4'h9);
    check_val("t4_count", 32'(count_o), 32'd6);
    check_val("t4_ready", 32'(ready_o), 32'd0);
    step_commit();
    repeat (2) step(1'b0, 3'b111, 12'hABC, 24'hDDEEFF, 1'b1, 4'hA);
    repeat (4) step(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h1);

    // 5: sustained traffic so pointers wrap
    for (int c = 0; c < 6; c++) begin
      ra = 12'($urandom); rd = 24'($urandom);
      step(1'b0, 3'b111, ra, rd, 1'b0, 4'($urandom_range(15, 0)));
    end
    repeat (5) step(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'($urandom_range(15, 0)));

    // 6: reset with five pending entries
    step(1'b0, 3'b111, 12'h321, 24'h010203, 1'b1, 4'h1);
    step(1'b0, 3'b011, 12'h654, 24'h040506, 1'b1, 4'h4);
    step(1'b1, 3'b000, 12'h0, 24'h0, 1'b1, 4'h4);
    step_drive(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h4);
    check_val("t6_count", 32'(count_o), 32'd0);
    check_val("t6_we0", 32'(we0_o), 32'd0);
    check_val("t6_ready", 32'(ready_o), 32'd1);
    step_commit();
    repeat (3) step(1'b0, 3'b000, 12'h0, 24'h0, 1'b0, 4'h1);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) ra[i*4 +: 4] = 4'($urandom_range(7, 0));
      rd = 24'($urandom);
      step(1'b0, 3'($urandom), ra, rd, ($urandom_range(9, 0) < 3), 4'($urandom_range(7, 0)));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
